rf_seq: RTL and testbench

- Command sequencer that acts as the initiator on the 4-entry × 4-bit register-bank port (addr / data_in / we / data_out).
- Accepts one command at a time over a start/ready/done handshake.
- Drives the bank's address, write-enable and write data, and captures the bank's registered read data.
- Sits between the datapath control logic and the register bank. It implements write-immediate, read, register copy and register add.

---
 rtl/rf_seq.sv | 139 +++++++++++++
 tb/tb_rf_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_seq.sv
// Command sequencer driving a small registered-read register bank.
// Executes WRITE, READ, COPY and ADD one command at a time.
module rf_seq #(
  parameter int DW = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [AW-1:0] src_a,
  input  logic [AW-1:0] src_b,
  input  logic [AW-1:0] dst,
  input  logic [DW-1:0] imm,
  output logic          ready,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic [AW-1:0] rf_addr,
  output logic          rf_we,
  output logic [DW-1:0] rf_wdata,
  input  logic [DW-1:0] rf_rdata
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_ADD   = 2'b11;

  typedef enum logic [2:0] {
    IDLE, RD_A, CAP_A, RD_B, CAP_B, WR, DONE
  } state_t;

  state_t        state;
  logic [1:0]    op_q;
  logic [AW-1:0] b_q;
  logic [AW-1:0] d_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] opa;
  logic [DW-1:0] sum_q;
  logic          cy_q;
  logic [DW:0]   add_w;

  // opb is consumed straight off the bank in CAP_B
  always_comb begin
    add_w = {1'b0, opa} + {1'b0, rf_rdata};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      rf_addr  <= '0;
      rf_we    <= 1'b0;
      rf_wdata <= '0;
      op_q     <= '0;
      b_q      <= '0;
      d_q      <= '0;
      imm_q    <= '0;
      opa      <= '0;
      sum_q    <= '0;
      cy_q     <= 1'b0;
    end else begin
      done     <= 1'b0;
      rf_we    <= 1'b0;
      rf_wdata <= '0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            b_q   <= src_b;
            d_q   <= dst;
            imm_q <= imm;
            ready <= 1'b0;
            if (op == OP_WRITE) begin
              state    <= WR;
              rf_addr  <= dst;
              rf_we    <= 1'b1;
              rf_wdata <= imm;
            end else begin
              state   <= RD_A;
              rf_addr <= src_a;
            end
          end
        end
        RD_A: state <= CAP_A;
        CAP_A: begin
          opa <= rf_rdata;
          if (op_q == OP_READ) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= rf_rdata;
            carry  <= 1'b0;
          end else if (op_q == OP_COPY) begin
            state    <= WR;
            rf_addr  <= d_q;
            rf_we    <= 1'b1;
            rf_wdata <= rf_rdata;
          end else begin
            state   <= RD_B;
            rf_addr <= b_q;
          end
        end
        RD_B: state <= CAP_B;
        CAP_B: begin
          sum_q    <= add_w[DW-1:0];
          cy_q     <= add_w[DW];
          state    <= WR;
          rf_addr  <= d_q;
          rf_we    <= 1'b1;
          rf_wdata <= add_w[DW-1:0];
        end
        WR: begin
          state <= DONE;
          done  <= 1'b1;
          carry <= (op_q == OP_ADD) ? cy_q : 1'b0;
          if (op_q == OP_WRITE)
            result <= imm_q;
          else if (op_q == OP_COPY)
            result <= opa;
          else
            result <= sum_q;
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_seq.sv
// Randomized bench for rf_seq with a bank model and a command-level
// reference model of bank contents, results and latencies.
module tb_rf_seq;
  localparam int DW = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = '0;
  logic [AW-1:0] src_a = '0;
  logic [AW-1:0] src_b = '0;
  logic [AW-1:0] dst = '0;
  logic [DW-1:0] imm = '0;
  logic          ready;
  logic          done;
  logic [DW-1:0] result;
  logic          carry;
  logic [AW-1:0] rf_addr;
  logic          rf_we;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_rdata;

  logic [DW-1:0] bank [4];
  logic [DW-1:0] mdl  [4];
  bit            vld  [4];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rf_seq #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .dst(dst), .imm(imm),
    .ready(ready), .done(done), .result(result), .carry(carry),
    .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata)
  );

  always @(posedge clk) begin
    if (rf_we) bank[rf_addr] <= rf_wdata;
    else rf_rdata <= bank[rf_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    op    = 2'($urandom);
    src_a = 2'($urandom);
    src_b = 2'($urandom);
    dst   = 2'($urandom);
    imm   = 4'($urandom);
  endtask

  // Called #1 after the accepting edge; returns #1 after ready is back.
  task automatic finish_cmd(input logic [1:0] o, input logic [1:0] a,
                            input logic [1:0] b, input logic [1:0] d,
                            input logic [3:0] im);
    int elat, cyc, nwe, wcyc;
    logic [1:0] wa;
    logic [3:0] wd, eres;
    logic [4:0] s;
    logic ec;
    bit ewr;
    wa = '0; wd = '0; nwe = 0; wcyc = 0; ec = 1'b0;
    case (o)
      2'd0: begin elat = 2; eres = im; ewr = 1; end
      2'd1: begin elat = 3; eres = mdl[a]; ewr = 0; end
      2'd2: begin elat = 4; eres = mdl[a]; ewr = 1; end
      default: begin
        elat = 6; ewr = 1;
        s = {1'b0, mdl[a]} + {1'b0, mdl[b]};
        eres = s[3:0]; ec = s[4];
      end
    endcase
    cyc = 1;
    while (!done && cyc <= 10) begin
      check("busy", ready, 0);
      if (rf_we) begin
        nwe++; wcyc = cyc; wa = rf_addr; wd = rf_wdata;
      end else begin
        check("wdata0", rf_wdata, 0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("done_seen", done, 1);
    check("latency", cyc, elat);
    check("nwrites", nwe, ewr ? 1 : 0);
    if (ewr) begin
      check("wr_cyc", wcyc, elat - 1);
      check("wr_addr", wa, d);
      check("wr_data", wd, eres);
    end
    check("result", result, eres);
    check("carry", carry, ec);
    check("rdy_done", ready, 0);
    if (ewr) begin mdl[d] = eres; vld[d] = 1; end
    @(posedge clk); #1;
    check("rdy_after", ready, 1);
    check("done_1cyc", done, 0);
    check("res_hold", result, eres);
    for (int i = 0; i < 4; i++)
      if (vld[i]) check($sformatf("bank%0d", i), bank[i], mdl[i]);
  endtask

  task automatic issue(input logic [1:0] o, input logic [1:0] a,
                       input logic [1:0] b, input logic [1:0] d,
                       input logic [3:0] im);
    @(negedge clk);
    check("rdy_idle", ready, 1);
    start = 1; op = o; src_a = a; src_b = b; dst = d; imm = im;
    @(posedge clk); #1;
    start = 0;
    scramble();
    finish_cmd(o, a, b, d, im);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 4; i++) vld[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry, 0);
    check("rst_addr", rf_addr, 0);
    check("rst_we", rf_we, 0);
    check("rst_wdata", rf_wdata, 0);
    @(negedge clk); rst_n = 1;

    issue(2'd0, 2'd0, 2'd0, 2'd2, 4'hA);
    issue(2'd0, 2'd0, 2'd0, 2'd1, 4'h5);
    issue(2'd0, 2'd0, 2'd0, 2'd0, 4'h3);
    issue(2'd0, 2'd0, 2'd0, 2'd3, 4'hE);
    issue(2'd1, 2'd1, 2'd0, 2'd0, 4'h0);
    issue(2'd2, 2'd0, 2'd0, 2'd3, 4'h0);
    issue(2'd1, 2'd3, 2'd0, 2'd0, 4'h0);
    issue(2'd0, 2'd0, 2'd0, 2'd1, 4'h9);
    issue(2'd0, 2'd0, 2'd0, 2'd2, 4'h8);
    issue(2'd3, 2'd1, 2'd2, 2'd1, 4'h0);
    issue(2'd0, 2'd0, 2'd0, 2'd2, 4'h2);
    issue(2'd3, 2'd1, 2'd2, 2'd1, 4'h0);
    issue(2'd3, 2'd2, 2'd2, 2'd0, 4'h0);

    // start held high across a whole ADD and its DONE cycle
    @(negedge clk);
    start = 1; op = 2'd3; src_a = 2'd0; src_b = 2'd1; dst = 2'd0;
    @(posedge clk); #1;
    finish_cmd(2'd3, 2'd0, 2'd1, 2'd0, 4'h0);
    @(posedge clk); #1;
    check("hold_accept", ready, 0);
    start = 0;
    scramble();
    finish_cmd(2'd3, 2'd0, 2'd1, 2'd0, 4'h0);

    // reset in the CAP_B cycle of an ADD into R3
    @(negedge clk);
    start = 1; op = 2'd3; src_a = 2'd1; src_b = 2'd2; dst = 2'd3;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 0;
    @(posedge clk); #1;
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_carry", carry, 0);
    check("abort_addr", rf_addr, 0);
    check("abort_we", rf_we, 0);
    check("abort_wdata", rf_wdata, 0);
    @(negedge clk); rst_n = 1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || rf_we) seen++;
    end
    check("abort_quiet", seen, 0);
    check("abort_dst", bank[3], mdl[3]);

    repeat (40) begin
      logic [1:0] o, a, b, d;
      logic [3:0] im;
      o = 2'($urandom); a = 2'($urandom); b = 2'($urandom);
      d = 2'($urandom); im = 4'($urandom);
      issue(o, a, b, d, im);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
